// File: rtl/boot_pkg.sv
// Shared types for the UART instruction-memory boot loader.
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } boot_state_e;

  // Debug classification of why a frame ended in ERR.
  typedef enum logic [1:0] {
    ERR_LEN   = 2'd0,
    ERR_TMO   = 2'd1,
    ERR_CSUM  = 2'd2,
    ERR_ABORT = 2'd3
  } boot_err_e;

  localparam logic [3:0] FULL_BMASK = 4'b1111;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/boot_word_packer.sv
// Assembles received bytes into little-endian 32-bit words; word_ready_o
// pulses combinationally with the 4th byte so word_o includes that byte.
module boot_word_packer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [1:0]  byte_idx_o,
  output logic        word_ready_o,
  output logic [31:0] word_o
);

  logic [23:0] buf_q, buf_d;
  logic [1:0]  idx_q, idx_d;

  // Earlier bytes shift toward the LSB so the first byte ends up in [7:0].
  always_comb begin
    buf_d = buf_q;
    idx_d = idx_q;
    if (clr_i) begin
      buf_d = 24'd0;
      idx_d = 2'd0;
    end else if (byte_valid_i) begin
      buf_d = {byte_i, buf_q[23:8]};
      idx_d = idx_q + 2'd1;
    end else begin
      buf_d = buf_q;
      idx_d = idx_q;
    end
  end

  // Byte buffer and lane index registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q <= 24'd0;
      idx_q <= 2'd0;
    end else begin
      buf_q <= buf_d;
      idx_q <= idx_d;
    end
  end

  assign byte_idx_o   = idx_q;
  assign word_ready_o = byte_valid_i && !clr_i && (idx_q == 2'd3);
  assign word_o       = {byte_i, buf_q};

endmodule

// File: rtl/imem_boot_ctrl.sv
// UART boot-load sequencer: frames length + words + checksum from the RX
// byte stream, writes words to instruction memory and gates CPU reset.
module imem_boot_ctrl import boot_pkg::*; #(
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_WADDR  = '0,
  parameter int unsigned       MAX_WORDS   = 2048,
  parameter int unsigned       TIMEOUT_CYC = 1000000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_boot_en,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  output logic              o_mem_wren,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_bmask,
  output logic              o_cpu_hold,
  output logic              o_boot_done,
  output logic              o_boot_err,
  output logic [31:0]       o_word_cnt
);

  boot_state_e       state_q, state_d;
  logic              boot_en_q;
  logic [31:0]       len_q, len_d;
  logic [7:0]        sum_q, sum_d;
  logic [31:0]       tmr_q, tmr_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        bmask_q;
  logic [31:0]       cnt_q, cnt_d;
  logic              hold_q, done_q, done_d, err_q;

  logic              start_s, accept_s, rise_s, tmr_run_s, tmo_s;
  logic [1:0]        pk_idx_s;
  logic              pk_ready_s;
  logic [31:0]       pk_word_s;

  boot_word_packer u_packer (
    .clk_i        (i_clk),
    .rst_ni       (i_reset),
    .clr_i        (start_s),
    .byte_valid_i (accept_s),
    .byte_i       (i_rx_data),
    .byte_idx_o   (pk_idx_s),
    .word_ready_o (pk_ready_s),
    .word_o       (pk_word_s)
  );

  // Byte acceptance, restart edge and inter-byte timeout qualification.
  always_comb begin
    accept_s  = i_rx_valid && i_boot_en && (state_q inside {LEN, DATA, CSUM});
    rise_s    = i_boot_en && !boot_en_q;
    tmr_run_s = ((state_q == LEN) && (pk_idx_s != 2'd0)) || (state_q == DATA) || (state_q == CSUM);
    tmo_s     = tmr_run_s && !accept_s && (tmr_q >= 32'(TIMEOUT_CYC - 1));
  end

  // Next-state, framing bookkeeping and write-register load.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    sum_d   = sum_q;
    tmr_d   = (tmr_run_s && !accept_s) ? tmr_q + 32'd1 : 32'd0;
    wren_d  = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    start_s = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_boot_en) begin
          state_d = LEN;
          start_s = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      LEN: begin
        if (!i_boot_en) begin
          state_d = ERR;
        end else if (accept_s && pk_ready_s) begin
          len_d = pk_word_s;
          if (pk_word_s == 32'd0) begin
            state_d = CSUM;
          end else if (pk_word_s > 32'(MAX_WORDS)) begin
            state_d = ERR;
          end else begin
            state_d = DATA;
          end
        end else if (tmo_s) begin
          state_d = ERR;
        end else begin
          state_d = LEN;
        end
      end
      DATA: begin
        if (!i_boot_en) begin
          state_d = ERR;
        end else if (accept_s) begin
          sum_d = csum_add(sum_q, i_rx_data);
          if (pk_ready_s) begin
            wren_d  = 1'b1;
            addr_d  = BASE_WADDR + ADDR_W'(cnt_q);
            wdata_d = pk_word_s;
            cnt_d   = cnt_q + 32'd1;
            if ((cnt_q + 32'd1) == len_q) begin
              state_d = CSUM;
            end else begin
              state_d = DATA;
            end
          end else begin
            state_d = DATA;
          end
        end else if (tmo_s) begin
          state_d = ERR;
        end else begin
          state_d = DATA;
        end
      end
      CSUM: begin
        if (!i_boot_en) begin
          state_d = ERR;
        end else if (accept_s) begin
          if (csum_add(sum_q, i_rx_data) == 8'd0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ERR;
          end
        end else if (tmo_s) begin
          state_d = ERR;
        end else begin
          state_d = CSUM;
        end
      end
      DONE, ERR: begin
        if (rise_s) begin
          state_d = LEN;
          start_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (start_s) begin
      len_d  = 32'd0;
      sum_d  = 8'd0;
      tmr_d  = 32'd0;
      cnt_d  = 32'd0;
      done_d = 1'b0;
    end else begin
      done_d = done_d;
    end
  end

  // State, framing and registered output update.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= IDLE;
      boot_en_q <= 1'b0;
      len_q     <= 32'd0;
      sum_q     <= 8'd0;
      tmr_q     <= 32'd0;
      wren_q    <= 1'b0;
      addr_q    <= BASE_WADDR;
      wdata_q   <= 32'd0;
      bmask_q   <= 4'b0000;
      cnt_q     <= 32'd0;
      hold_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      boot_en_q <= i_boot_en;
      len_q     <= len_d;
      sum_q     <= sum_d;
      tmr_q     <= tmr_d;
      wren_q    <= wren_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      bmask_q   <= wren_d ? FULL_BMASK : 4'b0000;
      cnt_q     <= cnt_d;
      hold_q    <= (state_d != DONE);
      done_q    <= done_d;
      err_q     <= (state_d == ERR);
    end
  end

  assign o_mem_wren  = wren_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_bmask = bmask_q;
  assign o_cpu_hold  = hold_q;
  assign o_boot_done = done_q;
  assign o_boot_err  = err_q;
  assign o_word_cnt  = cnt_q;

endmodule
